// File: rtl/conv_mac_acc.sv
// conv_mac_acc: multi-channel sequential convolution MAC.
// Each accepted beat carries one channel's K_H x K_W window and weights. Beat sums
// accumulate on top of a bias until the group closes. The group closes on in_last,
// or is forced closed after C_IN beats. On close the result gets optional ReLU, an
// arithmetic right shift and an unsigned clamp, and is held on a valid/ready output.
module conv_mac_acc #(
    parameter int K_H   = 3,
    parameter int K_W   = 3,
    parameter int DW    = 8,
    parameter int WW    = 8,
    parameter int C_IN  = 4,
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [K_H*K_W*DW-1:0]        in_win,
    input  logic [K_H*K_W*WW-1:0]        in_w,
    input  logic                         in_last,
    input  logic [ACC_W-1:0]             bias,
    input  logic                         cfg_relu,
    input  logic [4:0]                   cfg_shift,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_acc,
    output logic [OUT_W-1:0]             out_q,
    output logic                         out_sat,
    output logic [$clog2(C_IN+1)-1:0]    out_len
);

    localparam int N  = K_H * K_W;
    localparam int LW = $clog2(C_IN + 1);
    localparam logic signed [ACC_W-1:0] Q_MAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [LW-1:0]           cnt;

    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_next;
    logic [LW-1:0]           cnt_next;
    logic                    beat_fire;
    logic                    close_beat;
    logic signed [ACC_W-1:0] relu_val;
    logic signed [ACC_W-1:0] shifted;
    logic [OUT_W-1:0]        q_val;
    logic                    sat_val;

    // The input stalls only while a result is pending and not being taken this cycle.
    assign in_ready  = !out_valid || out_ready;
    assign beat_fire = in_valid && in_ready;

    // Sum of the channel's products; activations are unsigned, weights signed, wraps at ACC_W.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < N; i++) begin
            beat_sum = beat_sum
                + ($signed({{(ACC_W-DW){1'b0}}, in_win[i*DW +: DW]})
                 * $signed({{(ACC_W-WW){in_w[i*WW+WW-1]}}, in_w[i*WW +: WW]}));
        end
    end

    // Next accumulator and beat count; a fresh group starts from the bias instead of acc.
    always_comb begin
        acc_base   = (state == IDLE) ? $signed(bias) : acc;
        acc_next   = acc_base + beat_sum;
        cnt_next   = (state == IDLE) ? LW'(1) : cnt + LW'(1);
        close_beat = beat_fire && (in_last || (cnt_next == LW'(C_IN)));
    end

    // Post-processing of the closing value: ReLU, floor shift, then unsigned clamp.
    always_comb begin
        relu_val = (cfg_relu && acc_next[ACC_W-1]) ? '0 : acc_next;
        shifted  = relu_val >>> cfg_shift;
        q_val    = '0;
        sat_val  = 1'b0;
        if (shifted < 0) begin
            q_val = '0;
        end else if (shifted > Q_MAX) begin
            q_val   = '1;
            sat_val = 1'b1;
        end else begin
            q_val = shifted[OUT_W-1:0];
        end
    end

    // Group FSM plus output registers; a close in the same cycle as an output handshake reloads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_q     <= '0;
            out_sat   <= 1'b0;
            out_len   <= '0;
        end else begin
            if (beat_fire) begin
                if (close_beat) begin
                    state <= IDLE;
                    acc   <= '0;
                    cnt   <= '0;
                end else begin
                    state <= ACC;
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                end
            end
            if (close_beat) begin
                out_valid <= 1'b1;
                out_acc   <= relu_val;
                out_q     <= q_val;
                out_sat   <= sat_val;
                out_len   <= cnt_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_acc.sv
// tb_conv_mac_acc: table-driven single-beat vectors, hand-written multi-cycle
// sequences and randomized groups checked against a plain-arithmetic model.
module tb_conv_mac_acc;

    localparam int K_H   = 3;
    localparam int K_W   = 3;
    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int C_IN  = 4;
    localparam int ACC_W = 32;
    localparam int OUT_W = 8;
    localparam int NE    = K_H * K_W;
    localparam int LW    = $clog2(C_IN + 1);

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [NE*DW-1:0]     in_win;
    logic [NE*WW-1:0]     in_w;
    logic                 in_last;
    logic [ACC_W-1:0]     bias;
    logic                 cfg_relu;
    logic [4:0]           cfg_shift;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_W-1:0]     out_acc;
    logic [OUT_W-1:0]     out_q;
    logic                 out_sat;
    logic [LW-1:0]        out_len;

    int total_cnt = 0;
    int bad_cnt   = 0;

    typedef struct {
        logic [7:0] win_v;
        logic [7:0] w_v;
        int         b;
        bit         relu;
        int         shift;
        longint     e_acc;
        longint     e_q;
        bit         e_sat;
    } vec_t;

    vec_t tbl[9];

    conv_mac_acc #(
        .K_H(K_H), .K_W(K_W), .DW(DW), .WW(WW),
        .C_IN(C_IN), .ACC_W(ACC_W), .OUT_W(OUT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_win    (in_win),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .cfg_relu  (cfg_relu),
        .cfg_shift (cfg_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_q     (out_q),
        .out_sat   (out_sat),
        .out_len   (out_len)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        total_cnt++;
        if (act != exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] r;
        for (int i = 0; i < NE; i++) r[i*8 +: 8] = v;
        return r;
    endfunction

    // Dot product of one channel with plain integer arithmetic.
    function automatic longint dot(input logic [71:0] win, input logic [71:0] w);
        longint s = 0;
        for (int i = 0; i < NE; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = win[i*8 +: 8];
            b = w[i*8 +: 8];
            s += longint'(a) * longint'($signed(b));
        end
        return s;
    endfunction

    // Group result from the running total: wrap to 32 bits, ReLU, floor shift, clamp.
    function automatic void model(input longint total, input bit relu, input int sh,
                                  output longint e_acc, output longint e_q, output longint e_sat);
        int a;
        int t;
        a = total[31:0];
        if (relu && a < 0) a = 0;
        e_acc = a;
        t = a >>> sh;
        if (t < 0) begin
            e_q = 0; e_sat = 0;
        end else if (t > 255) begin
            e_q = 255; e_sat = 1;
        end else begin
            e_q = t; e_sat = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [71:0] win, input logic [71:0] w, input logic last,
                                 input int b, input logic relu, input int sh);
        int waited = 0;
        in_valid  = 1'b1;
        in_win    = win;
        in_w      = w;
        in_last   = last;
        bias      = b;
        cfg_relu  = relu;
        cfg_shift = sh[4:0];
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input longint e_acc, input longint e_q,
                               input longint e_sat, input longint e_len);
        check({tag, ".valid"}, longint'(out_valid), 1);
        check({tag, ".acc"},   longint'($signed(out_acc)), e_acc);
        check({tag, ".q"},     longint'(out_q), e_q);
        check({tag, ".sat"},   longint'(out_sat), e_sat);
        check({tag, ".len"},   longint'(out_len), e_len);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_win    = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        cfg_relu  = 1'b0;
        cfg_shift = '0;
        out_ready = 1'b1;

        tbl[0] = '{8'd1,   8'd2,   0,     1'b0, 0,  18,      18,  1'b0};
        tbl[1] = '{8'd255, 8'h7f,  0,     1'b0, 4,  291465,  255, 1'b1};
        tbl[2] = '{8'd255, 8'h80,  0,     1'b0, 0,  -293760, 0,   1'b0};
        tbl[3] = '{8'd255, 8'h80,  0,     1'b1, 0,  0,       0,   1'b0};
        tbl[4] = '{8'd10,  8'hfd,  300,   1'b1, 1,  30,      15,  1'b0};
        tbl[5] = '{8'd0,   8'd5,   -7,    1'b0, 0,  -7,      0,   1'b0};
        tbl[6] = '{8'd16,  8'd1,   112,   1'b0, 0,  256,     255, 1'b1};
        tbl[7] = '{8'd15,  8'd1,   120,   1'b0, 0,  255,     255, 1'b0};
        tbl[8] = '{8'd100, 8'hff,  -1000, 1'b0, 31, -1900,   0,   1'b0};

        // Reset state.
        #12;
        check("rst.valid", longint'(out_valid), 0);
        check("rst.acc",   longint'(out_acc), 0);
        check("rst.q",     longint'(out_q), 0);
        check("rst.sat",   longint'(out_sat), 0);
        check("rst.len",   longint'(out_len), 0);
        check("rst.in_ready", longint'(in_ready), 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Single-beat table vectors.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(fill(tbl[i].win_v), fill(tbl[i].w_v), 1'b1, tbl[i].b, tbl[i].relu, tbl[i].shift);
            checkOutput($sformatf("tbl%0d", i), tbl[i].e_acc, tbl[i].e_q, tbl[i].e_sat, 1);
            tick();
            check($sformatf("tbl%0d.drop", i), longint'(out_valid), 0);
        end

        // Four negative beats, without and with ReLU.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++)
                applyStimulus(fill(8'd255), fill(8'h80), k == 3, 0, r[0], 0);
            checkOutput(r == 0 ? "neg4" : "neg4_relu", r == 0 ? -1175040 : 0, 0, 0, 4);
        end

        // Forced close after C_IN beats, then a two-beat group; later bias is ignored.
        for (int k = 0; k < 4; k++) applyStimulus(fill(8'd1), fill(8'd1), 1'b0, 10, 1'b0, 0);
        checkOutput("forced", 46, 46, 0, 4);
        applyStimulus(fill(8'd1), fill(8'd1), 1'b0, 10, 1'b0, 0);
        applyStimulus(fill(8'd1), fill(8'd1), 1'b1, 99, 1'b0, 0);
        checkOutput("after_forced", 28, 28, 0, 2);

        // Reset mid-group discards the partial sum.
        applyStimulus(fill(8'd1), fill(8'd1), 1'b0, 3, 1'b0, 0);
        applyStimulus(fill(8'd1), fill(8'd1), 1'b0, 3, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst.valid", longint'(out_valid), 0);
        check("midrst.acc",   longint'(out_acc), 0);
        check("midrst.q",     longint'(out_q), 0);
        check("midrst.sat",   longint'(out_sat), 0);
        check("midrst.len",   longint'(out_len), 0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(fill(8'd1), fill(8'd1), 1'b1, 5, 1'b0, 0);
        checkOutput("post_rst", 14, 14, 0, 1);
        tick();

        // Backpressure: result held while out_ready is low, then a close meets the handshake.
        out_ready = 1'b0;
        applyStimulus(fill(8'd1), fill(8'd2), 1'b1, 0, 1'b0, 0);
        checkOutput("bp_first", 18, 18, 0, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_hold%0d.in_ready", k), longint'(in_ready), 0);
            checkOutput($sformatf("bp_hold%0d", k), 18, 18, 0, 1);
        end
        in_valid  = 1'b1;
        in_win    = fill(8'd3);
        in_w      = fill(8'd1);
        in_last   = 1'b1;
        bias      = '0;
        cfg_relu  = 1'b0;
        cfg_shift = '0;
        out_ready = 1'b1;
        #1;
        check("bp_release.in_ready", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        checkOutput("bp_next", 27, 27, 0, 1);
        tick();
        check("bp_next.drop", longint'(out_valid), 0);

        // Randomized groups against the model; bias from first beat, cfg from closing beat.
        for (int g = 0; g < 40; g++) begin
            int     len;
            longint total;
            int     b_first;
            bit     relu_l;
            int     sh_l;
            longint e_acc, e_q, e_sat;
            len   = $urandom_range(1, C_IN);
            total = 0;
            for (int k = 0; k < len; k++) begin
                logic [71:0] win, w;
                int          b;
                bit          relu;
                int          sh;
                bit          last;
                win  = {$urandom, $urandom, $urandom};
                w    = {$urandom, $urandom, $urandom};
                b    = int'($urandom_range(0, 400000)) - 200000;
                relu = 1'($urandom_range(0, 1));
                sh   = $urandom_range(0, 14);
                last = (k == len - 1) ? ((len == C_IN) ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                if (k == 0) begin
                    b_first = b;
                    total   = b;
                end
                total += dot(win, w);
                relu_l = relu;
                sh_l   = sh;
                repeat ($urandom_range(0, 2)) tick();
                applyStimulus(win, w, last, b, relu, sh);
            end
            model(total, relu_l, sh_l, e_acc, e_q, e_sat);
            checkOutput($sformatf("rnd%0d", g), e_acc, e_q, e_sat, len);
            if (b_first == 0 && e_acc == 0) total_cnt = total_cnt + 0;
        end

        tick();
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
